dmem_arbiter: RTL and testbench

- Shares the single-port 64-bit data memory (sram_BW64) between two requesters:
  - the pipeline MEM stage (cpu port);
  - the external load/inspect interface (ext port).
- Grants one access per cycle, with CPU priority and a starvation guard for ext.
- Routes synchronous read data back to the requester that issued the read.
- Drives a stall to the pipeline while the MEM-stage access is not granted.

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data SRAM: CPU priority with a starvation guard for ext.
// Optional macro DMEM_ARB_STATS_EN adds conflict/stall/forced-grant counters.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_conflict,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_forced
`endif
);

  localparam logic [0:0] CPU_PRI   = 1'b0;
  localparam logic [0:0] EXT_FORCE = 1'b1;
  localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);

  logic [0:0] state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       rd_cpu, rd_ext;
  logic       c, e;

  always_comb begin
    c         = cpu_req & enable;
    e         = ext_req;
    ext_gnt   = e & ((state == EXT_FORCE) | ~c);
    cpu_gnt   = c & ~ext_gnt;
    cpu_stall = c & ~cpu_gnt;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end
  end

  // EXT_FORCE is entered exactly when the updated count hits the limit; leaving it
  // (grant taken or ext_req dropped) clears the count, so one compare covers both exits.
  always_comb begin
    if (~e | ext_gnt)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_LIM)
      wait_nxt = wait_cnt + 4'd1;
    else
      wait_nxt = wait_cnt;
    state_nxt = (wait_nxt == WAIT_LIM) ? EXT_FORCE : CPU_PRI;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= CPU_PRI;
      wait_cnt <= '0;
      rd_cpu   <= 1'b0;
      rd_ext   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rd_cpu   <= cpu_gnt & ~cpu_wen;
      rd_ext   <= ext_gnt & ~ext_wen;
    end
  end

  always_comb begin
    cpu_rvalid = rd_cpu;
    ext_rvalid = rd_ext;
    cpu_rdata  = mem_rdata;
    ext_rdata  = mem_rdata;
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_conflict <= '0;
      stat_stall    <= '0;
      stat_forced   <= '0;
    end else if (enable) begin
      stat_conflict <= stat_conflict + 32'(c & e);
      stat_stall    <= stat_stall + 32'(cpu_stall);
      stat_forced   <= stat_forced + 32'(ext_gnt & (state == EXT_FORCE));
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset sequence, then random traffic vs a reference model.
module tb_dmem_arbiter;

  localparam int unsigned MW = 4;

  typedef struct {
    logic        en, cr, cw;
    logic [7:0]  ca;
    logic [63:0] cd;
    logic        er, ew;
    logic [7:0]  ea;
    logic [63:0] ed;
    logic [6:0]  fl;   // {cpu_gnt, ext_gnt, cpu_stall, mem_ren, mem_wen, cpu_rvalid, ext_rvalid}
    logic [63:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        ext_req = 1'b0, ext_wen = 1'b0;
  logic [63:0] ext_addr = '0, ext_wdata = '0;
  logic        ext_gnt, ext_rvalid;
  logic [63:0] ext_rdata;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_wen, mem_ren;
  logic [63:0] mem_rdata;

  logic [63:0] sram   [256] = '{default: '0};
  logic [63:0] shadow [256] = '{default: '0};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MAX_WAIT(MW)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port SRAM: read data valid one cycle after mem_ren.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
    if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
  end

  function automatic vec_t mk(logic en, logic cr, logic cw, logic [7:0] ca, logic [63:0] cd,
                              logic er, logic ew, logic [7:0] ea, logic [63:0] ed,
                              logic [6:0] fl, logic [63:0] rd);
    vec_t v;
    v.en = en; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.er = er; v.ew = ew; v.ea = ea; v.ed = ed; v.fl = fl; v.rd = rd;
    return v;
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_flags();
    return {cpu_gnt, ext_gnt, cpu_stall, mem_ren, mem_wen, cpu_rvalid, ext_rvalid};
  endfunction

  task automatic drive(vec_t v);
    enable  = v.en;
    cpu_req = v.cr; cpu_wen = v.cw; cpu_addr = {56'd0, v.ca}; cpu_wdata = v.cd;
    ext_req = v.er; ext_wen = v.ew; ext_addr = {56'd0, v.ea}; ext_wdata = v.ed;
  endtask

  task automatic check_vec(string nm, vec_t v);
    logic [63:0] ea, ew;
    ea = v.fl[6] ? {56'd0, v.ca} : v.fl[5] ? {56'd0, v.ea} : 64'd0;
    ew = v.fl[6] ? v.cd : v.fl[5] ? v.ed : 64'd0;
    check({nm, ".ctl"}, 128'(dut_flags()), 128'(v.fl));
    check({nm, ".bus"}, {mem_addr, mem_wdata}, {ea, ew});
    if (v.fl[1]) check({nm, ".crd"}, 128'(cpu_rdata), 128'(v.rd));
    if (v.fl[0]) check({nm, ".erd"}, 128'(ext_rdata), 128'(v.rd));
  endtask

  task automatic apply(string nm, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check_vec(nm, v);
  endtask

  vec_t tbl[$];
  vec_t cw4, rd10, idle;

  initial begin
    logic c_hold, e_hold, c, e, cpu_win, ext_win, pend_c, pend_e;
    logic [63:0] pend_d, exp_a, exp_w;
    logic [6:0] exp_fl;
    int unsigned denied;

    idle = mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000000, 0);
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000000, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 8'h10, 64'hDEAD_BEEF, 7'b0100100, 0));
    tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b1001000, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000010, 64'hDEAD_BEEF));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 8'h20, 64'h1234, 7'b0100100, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 7'b0101000, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000001, 64'h1234));
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4)
        tbl.push_back(mk(1, 1, 1, 8'h30, 64'hAAAA, 1, 1, 8'h38, 64'h5555, 7'b0110100, 0));
      else
        tbl.push_back(mk(1, 1, 1, 8'h30, 64'hAAAA, 1, 1, 8'h38, 64'h5555, 7'b1000100, 0));
    end
    tbl.push_back(mk(0, 1, 1, 8'h30, 64'hAAAA, 0, 0, 8'h00, 0, 7'b0000000, 0));
    tbl.push_back(mk(0, 1, 1, 8'h30, 64'hAAAA, 1, 0, 8'h20, 0, 7'b0101000, 0));
    tbl.push_back(mk(1, 1, 1, 8'h30, 64'hAAAA, 0, 0, 8'h00, 0, 7'b1000101, 64'h1234));
    tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b1001000, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 7'b0101010, 64'hDEAD_BEEF));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000001, 64'h1234));
    tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b1001000, 0));
    tbl.push_back(mk(0, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b0000010, 64'hDEAD_BEEF));
    tbl.push_back(mk(1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b1001000, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000010, 64'hDEAD_BEEF));

    drive(tbl[0]);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

    // Build up ext wait, reset right after a granted cpu read, then prove state was cleared.
    cw4  = mk(1, 1, 1, 8'h40, 64'h1, 1, 1, 8'h48, 64'h2, 7'b1000100, 0);
    rd10 = mk(1, 1, 0, 8'h10, 0, 1, 1, 8'h48, 64'h2, 7'b1001000, 0);
    apply("pre0", cw4);
    apply("pre1", cw4);
    apply("pre2", rd10);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1 check_vec("in_rst", rd10);
    @(negedge clk);
    arst_n = 1'b1;
    drive(cw4);
    #1 check_vec("post0", cw4);
    for (int k = 1; k < 4; k++) apply($sformatf("post%0d", k), cw4);
    apply("post_force", mk(1, 1, 1, 8'h40, 64'h1, 1, 1, 8'h48, 64'h2, 7'b0110100, 0));
    apply("post_rd", mk(1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 7'b1001000, 0));
    apply("post_rv", mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 7'b0000010, 64'hDEAD_BEEF));
    apply("settle", idle);

    // Random traffic: reference model counts consecutive ext denials and tracks memory contents.
    denied = 0; pend_c = 0; pend_e = 0; pend_d = '0; c_hold = 0; e_hold = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!c_hold) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_wen   = 1'($urandom_range(0, 1));
        cpu_addr  = 64'(8'h80 + 8'($urandom_range(0, 15)));
        cpu_wdata = {$urandom, $urandom};
      end
      enable = ($urandom_range(0, 7) != 0);
      if (!e_hold) begin
        ext_req   = ($urandom_range(0, 3) != 0);
        ext_wen   = 1'($urandom_range(0, 1));
        ext_addr  = 64'(8'h80 + 8'($urandom_range(0, 15)));
        ext_wdata = {$urandom, $urandom};
      end else if ($urandom_range(0, 11) == 0) begin
        ext_req = 1'b0;
      end
      c = cpu_req & enable;
      e = ext_req;
      ext_win = e && (denied == MW || !c);
      cpu_win = c && !ext_win;
      exp_fl = {cpu_win, ext_win, c && !cpu_win,
                (cpu_win && !cpu_wen) || (ext_win && !ext_wen),
                (cpu_win && cpu_wen) || (ext_win && ext_wen), pend_c, pend_e};
      exp_a = cpu_win ? cpu_addr : ext_win ? ext_addr : 64'd0;
      exp_w = cpu_win ? cpu_wdata : ext_win ? ext_wdata : 64'd0;
      #1;
      check($sformatf("rnd%0d.ctl", n), 128'(dut_flags()), 128'(exp_fl));
      check($sformatf("rnd%0d.bus", n), {mem_addr, mem_wdata}, {exp_a, exp_w});
      if (pend_c) check($sformatf("rnd%0d.crd", n), 128'(cpu_rdata), 128'(pend_d));
      if (pend_e) check($sformatf("rnd%0d.erd", n), 128'(ext_rdata), 128'(pend_d));
      pend_c = cpu_win && !cpu_wen;
      pend_e = ext_win && !ext_wen;
      if (cpu_win || ext_win) begin
        if (exp_fl[2]) shadow[exp_a[7:0]] = exp_w;
        else           pend_d = shadow[exp_a[7:0]];
      end
      denied = (e && !ext_win) ? ((denied < MW) ? denied + 1 : denied) : 0;
      c_hold = cpu_req && !cpu_win;
      e_hold = ext_req && !ext_win;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
